// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier. It performs one Booth step per clock.
// Optional feature macro: BOOTH_UNSIGNED_EN. When it is defined, the block adds
// a tc port. The operands are then widened by one bit (sign- or zero-extended),
// so one datapath handles both signed and unsigned multiplies.
module booth_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mc,
  input  logic [WIDTH-1:0]     mp,
`ifdef BOOTH_UNSIGNED_EN
  input  logic                 tc,
`endif
  output logic [2*WIDTH-1:0]   prod,
  output logic                 busy,
  output logic                 done
);

`ifdef BOOTH_UNSIGNED_EN
  localparam int unsigned OW = WIDTH + 1;
`else
  localparam int unsigned OW = WIDTH;
`endif
  localparam int unsigned ITER = OW;
  localparam int unsigned CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q, state_d;
  logic [OW-1:0]       a_q, a_d;
  logic [OW-1:0]       m_q, m_d;
  logic [OW-1:0]       q_q, q_d;
  logic                q_1_q, q_1_d;
  logic [CW-1:0]       count_q, count_d;
  logic [2*WIDTH-1:0]  prod_q, prod_d;

  logic [OW-1:0]       mc_ext, mp_ext;
  logic [OW:0]         sum;
  logic [OW-1:0]       a_step, q_step;
  logic [2*OW-1:0]     full_step;

  // Operand extension. The tc value is captured here, in the loaded operands.
  always_comb begin
`ifdef BOOTH_UNSIGNED_EN
    mc_ext = {tc & mc[WIDTH-1], mc};
    mp_ext = {tc & mp[WIDTH-1], mp};
`else
    mc_ext = mc;
    mp_ext = mp;
`endif
  end

  // One Booth step. The add is one bit wider so the shifted-in bit is the true sign.
  always_comb begin
    case ({q_q[0], q_1_q})
      2'b01:   sum = {a_q[OW-1], a_q} + {m_q[OW-1], m_q};
      2'b10:   sum = {a_q[OW-1], a_q} - {m_q[OW-1], m_q};
      default: sum = {a_q[OW-1], a_q};
    endcase
    a_step    = sum[OW:1];
    q_step    = {sum[0], q_q[OW-1:1]};
    full_step = {a_step, q_step};
  end

  // Next-state logic for the FSM and the datapath, plus the status outputs.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q_1_d   = q_1_q;
    count_d = count_q;
    prod_d  = prod_q;
    busy    = (state_q == StCalc);
    done    = (state_q == StDone);
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = '0;
          m_d     = mc_ext;
          q_d     = mp_ext;
          q_1_d   = 1'b0;
          count_d = CW'(ITER);
          state_d = StCalc;
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        a_d     = a_step;
        q_d     = q_step;
        q_1_d   = q_q[0];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          prod_d  = full_step[2*WIDTH-1:0];
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers, with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q_1_q   <= 1'b0;
      count_q <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q_1_q   <= q_1_d;
      count_q <= count_d;
      prod_q  <= prod_d;
    end
  end

  assign prod = prod_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed, table-driven bench for booth_mul_seq with WIDTH=8.
module tb_booth_mul_seq;

`ifdef BOOTH_UNSIGNED_EN
  localparam int ITER = 9;
`else
  localparam int ITER = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  mc = '0;
  logic [7:0]  mp = '0;
`ifdef BOOTH_UNSIGNED_EN
  logic        tc = 1'b1;
`endif
  logic [15:0] prod;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  booth_mul_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mc    (mc),
    .mp    (mp),
`ifdef BOOTH_UNSIGNED_EN
    .tc    (tc),
`endif
    .prod  (prod),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        t;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string nm, input string what, input longint act,
                       input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s %s: got 0x%0h, expected 0x%0h", nm, what, act, exp);
    end
  endtask

  // Called at the first negedge after the accepting edge. It returns the number
  // of negedges waited until done was seen, the busy cycles seen before that,
  // and whether prod stayed stable meanwhile.
  task automatic wait_done(output int k, output int busy_cnt, output bit hold_ok);
    logic [15:0] p0;
    p0 = prod;
    k = 0;
    busy_cnt = 0;
    hold_ok = 1'b1;
    while (!done && k < ITER + 6) begin
      if (busy) busy_cnt++;
      if (prod !== p0) hold_ok = 1'b0;
      @(negedge clk);
      k++;
    end
  endtask

  // Done is seen at negedge ITER, i.e. it is high in the cycle closed by edge ITER+1.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic t,
                        input logic [15:0] exp, input string nm);
    int k, bc;
    bit ho;
    mc = a;
    mp = b;
`ifdef BOOTH_UNSIGNED_EN
    tc = t;
`endif
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mc = ~a;
    mp = 8'($urandom);
`ifdef BOOTH_UNSIGNED_EN
    tc = ~t;
`endif
    wait_done(k, bc, ho);
    check(nm, "done edge", k + 1, ITER + 1);
    check(nm, "busy cycles", bc, ITER);
    check(nm, "prod hold in calc", ho, 1);
    check(nm, "prod", prod, exp);
    @(negedge clk);
    check(nm, "done pulse width", done, 0);
    check(nm, "prod hold after", prod, exp);
  endtask

  initial begin
    vec_t vecs[$];
    int   k, bc, ndone;
    bit   ho;
    string nm;

    vecs.push_back('{8'h03, 8'hFC, 1'b1, 16'hFFF4});
    vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
    vecs.push_back('{8'h7F, 8'h80, 1'b1, 16'hC080});
    vecs.push_back('{8'h80, 8'h7F, 1'b1, 16'hC080});
    vecs.push_back('{8'h7F, 8'h7F, 1'b1, 16'h3F01});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001});
    vecs.push_back('{8'h00, 8'h55, 1'b1, 16'h0000});
    vecs.push_back('{8'h80, 8'h01, 1'b1, 16'hFF80});
    vecs.push_back('{8'hFF, 8'h80, 1'b1, 16'h0080});
    vecs.push_back('{8'h12, 8'h34, 1'b1, 16'h03A8});
    vecs.push_back('{8'hF6, 8'h0A, 1'b1, 16'hFF9C});
`ifdef BOOTH_UNSIGNED_EN
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 16'h4000});
    vecs.push_back('{8'hFF, 8'h02, 1'b0, 16'h01FE});
    vecs.push_back('{8'hFF, 8'h02, 1'b1, 16'hFFFE});
`endif

    // Reset state
    #2;
    check("reset", "prod", prod, 0);
    check("reset", "busy", busy, 0);
    check("reset", "done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      nm = $sformatf("vec%0d", i);
      run_op(vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].exp, nm);
    end

    // A start pulse during CALC is ignored. Then a start in DONE runs back-to-back.
    mc = 8'd5;
    mp = 8'd6;
`ifdef BOOTH_UNSIGNED_EN
    tc = 1'b1;
`endif
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    mc = 8'd7;
    mp = 8'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(k, bc, ho);
    check("ignore", "done edge", k + 3 + 1, ITER + 1);
    check("ignore", "prod", prod, 16'h001E);
    // Now sitting in the DONE cycle; accept 7x7 here.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(k, bc, ho);
    check("b2b", "done edge", k + 1, ITER + 1);
    check("b2b", "busy cycles", bc, ITER);
    check("b2b", "prod", prod, 16'h0031);
    ndone = 0;
    for (int i = 0; i < 2 * ITER; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("b2b", "extra done pulses", ndone, 0);

    // Reset in the 4th CALC cycle abandons the operation.
    mc = 8'd9;
    mp = 8'd9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("midrst", "busy before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst", "prod", prod, 0);
    check("midrst", "busy", busy, 0);
    check("midrst", "done", done, 0);
    ndone = 0;
    for (int i = 0; i < 2 * ITER; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done) ndone++;
    end
    check("midrst", "done pulses", ndone, 0);
    check("midrst", "prod after idle", prod, 0);
    run_op(8'd2, 8'd3, 1'b1, 16'h0006, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
